// File: rtl/calc_pkg.sv
// Shared definitions for the calculator clock-rate controller slice.
package calc_pkg;

    // Default width of the divisor and the half-period counter
    localparam int DIV_W_DEF = 32;

    // Controller states: stopped, running, running with a divisor queued
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } rate_state_t;

endpackage

// File: rtl/clk_rate_ctrl_if.sv
// Divisor-configuration handshake between a host and clk_rate_ctrl.
interface clk_rate_ctrl_if
    import calc_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             busy;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err,
        input  busy
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err,
        output busy
    );
endinterface

// File: rtl/clk_rate_ctrl_div_counter.sv
// Half-period divide counter with registered clk_out and tick outputs.
// While run is low the counter and clk_out are parked at zero.
module div_counter #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div_active,
    output logic             tc,
    output logic             clk_out,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tc = run && (count == (div_active - DIV_W'(1)));

    // Count half-periods; toggle clk_out and strobe tick at terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!run) begin
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (tc) begin
            count   <= '0;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
        end else begin
            count   <= count + DIV_W'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_rate_ctrl.sv
// Run-time slow-clock controller: accepts divisors over a valid/ready
// handshake and applies divisor changes and stops only on the falling
// edge of clk_out, so downstream logic never sees a runt pulse.
module clk_rate_ctrl
    import calc_pkg::*;
#(
    parameter int          DIV_W   = DIV_W_DEF,
    parameter int unsigned DEF_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    clk_rate_ctrl_if.slave        cfg,
    output logic                  clk_out,
    output logic                  tick
);

    rate_state_t      state, state_n;
    logic [DIV_W-1:0] div_active, div_active_n;
    logic [DIV_W-1:0] div_pend, div_pend_n;
    logic             cfg_err_n;
    logic             tc;
    logic             fpb;
    logic             xfer;
    logic             div_zero;

    assign cfg.cfg_ready = (state != PEND);
    assign cfg.busy      = (state == PEND);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign div_zero      = (cfg.cfg_div == '0);
    assign fpb           = tc && clk_out;

    div_counter #(
        .DIV_W (DIV_W)
    ) u_div_counter (
        .clk        (clk),
        .rst        (rst),
        .run        (state != IDLE),
        .div_active (div_active),
        .tc         (tc),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    // State, divisor and error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            div_active  <= DIV_W'(DEF_DIV);
            div_pend    <= '0;
            cfg.cfg_err <= 1'b0;
        end else begin
            state       <= state_n;
            div_active  <= div_active_n;
            div_pend    <= div_pend_n;
            cfg.cfg_err <= cfg_err_n;
        end
    end

    // Next-state logic: accept divisors and commit them or stop at the period boundary.
    // A divisor accepted on the same edge as a stop request defers the stop to the next boundary.
    always_comb begin
        state_n      = state;
        div_active_n = div_active;
        div_pend_n   = div_pend;
        cfg_err_n    = xfer && div_zero;

        case (state)
            IDLE: begin
                if (xfer && !div_zero) begin
                    div_active_n = cfg.cfg_div;
                end
                if (en) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (xfer && !div_zero) begin
                    div_pend_n = cfg.cfg_div;
                    state_n    = PEND;
                end else if (fpb && !en) begin
                    state_n = IDLE;
                end
            end
            PEND: begin
                if (fpb) begin
                    div_active_n = div_pend;
                    state_n      = en ? RUN : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Self-checking bench for clk_rate_ctrl: directed scenarios then random
// traffic, all compared against a period-position reference model.
module tb_clk_rate_ctrl;
    import calc_pkg::*;

    localparam int DW  = 32;
    localparam int DEF = 4;

    logic clk;
    logic rst;
    logic en;
    logic clk_out;
    logic tick;

    int n_checks;
    int n_fail;

    // Reference model: position within the current full period
    bit          running;
    int          ph;
    int unsigned m_div;
    int unsigned m_pend;
    bit          has_pend;
    bit          m_clk;
    bit          m_tick;
    bit          m_err;

    clk_rate_ctrl_if #(.DIV_W(DW)) cfg_bus ();

    clk_rate_ctrl #(
        .DIV_W   (DW),
        .DEF_DIV (DEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg     (cfg_bus.slave),
        .clk_out (clk_out),
        .tick    (tick)
    );

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        running  = 1'b0;
        ph       = 0;
        m_div    = DEF;
        m_pend   = 0;
        has_pend = 1'b0;
        m_clk    = 1'b0;
        m_tick   = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic modelStep(input bit e_in, input bit v, input int unsigned d);
        bit ready;
        bit xfer;
        ready  = !has_pend;
        xfer   = v && ready;
        m_err  = xfer && (d == 0);
        m_tick = 1'b0;
        if (!running) begin
            m_clk = 1'b0;
            if (xfer && d != 0) m_div = d;
            if (e_in) begin
                running = 1'b1;
                ph      = 0;
            end
        end else begin
            ph++;
            if (ph == 2 * int'(m_div)) begin
                ph     = 0;
                m_tick = 1'b1;
                m_clk  = 1'b0;
                if (has_pend) begin
                    m_div    = m_pend;
                    has_pend = 1'b0;
                    if (!e_in) running = 1'b0;
                end else if (xfer && d != 0) begin
                    m_pend   = d;
                    has_pend = 1'b1;
                end else if (!e_in) begin
                    running = 1'b0;
                end
            end else begin
                if (ph == int'(m_div)) begin
                    m_tick = 1'b1;
                    m_clk  = 1'b1;
                end
                if (xfer && d != 0) begin
                    m_pend   = d;
                    has_pend = 1'b1;
                end
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("clk_out",   clk_out,           m_clk);
        checkOutput("tick",      tick,              m_tick);
        checkOutput("busy",      cfg_bus.busy,      has_pend);
        checkOutput("cfg_ready", cfg_bus.cfg_ready, !has_pend);
        checkOutput("cfg_err",   cfg_bus.cfg_err,   m_err);
    endtask

    task automatic applyStimulus(input bit e_in, input bit v, input int unsigned d);
        en                = e_in;
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_div   = DW'(d);
        @(posedge clk);
        modelStep(e_in, v, d);
        #1;
        compareAll();
    endtask

    initial begin
        bit reached;
        n_checks = 0;
        n_fail   = 0;
        modelReset();
        rst               = 1'b0;
        en                = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        repeat (2) @(posedge clk);
        #1;
        compareAll();
        rst = 1'b1;

        // Idle without en: outputs stay parked
        repeat (3) applyStimulus(1'b0, 1'b0, 0);

        // Free run at the default divisor
        repeat (20) applyStimulus(1'b1, 1'b0, 0);

        // Reset asserted mid high phase with count at 2
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            applyStimulus(1'b1, 1'b0, 0);
            reached = (m_clk && ph == int'(m_div) + 2);
        end
        checkOutput("reach_reset_point", reached, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(posedge clk);
        #1;
        compareAll();
        rst = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b0, 0);

        // Reconfigure to 2 at count 1 of a high phase, then a refused second offer
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            applyStimulus(1'b1, 1'b0, 0);
            reached = (m_clk && ph == int'(m_div) + 1);
        end
        checkOutput("reach_reconfig_point", reached, 1'b1);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 3);
        repeat (14) applyStimulus(1'b1, 1'b0, 0);

        // Zero divisor is rejected while running
        applyStimulus(1'b1, 1'b1, 0);
        repeat (10) applyStimulus(1'b1, 1'b0, 0);

        // Restore divisor 4, then stop during a low phase
        applyStimulus(1'b1, 1'b1, 4);
        repeat (12) applyStimulus(1'b1, 1'b0, 0);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            applyStimulus(1'b1, 1'b0, 0);
            reached = (running && !has_pend && !m_clk && ph == 1);
        end
        checkOutput("reach_stop_point", reached, 1'b1);
        repeat (14) applyStimulus(1'b0, 1'b0, 0);
        checkOutput("stopped_clk_out", clk_out, 1'b0);

        // Load divisor 1 in IDLE together with en
        applyStimulus(1'b1, 1'b1, 1);
        repeat (8) applyStimulus(1'b1, 1'b0, 0);
        repeat (4) applyStimulus(1'b0, 1'b0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 19) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
